// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch / data) arbiter in front of a single memory-controller port.
// Round-robin on contention; a watchdog turns a stuck access into an error completion.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    if_req,
    input  logic [ADDR_WIDTH-1:0]   if_addr,
    output logic                    if_ack,
    output logic [DATA_WIDTH-1:0]   if_rdata,
    output logic                    if_err,
    input  logic                    d_req,
    input  logic                    d_we,
    input  logic [ADDR_WIDTH-1:0]   d_addr,
    input  logic [DATA_WIDTH-1:0]   d_wdata,
    input  logic [DATA_WIDTH/8-1:0] d_wmask,
    output logic                    d_ack,
    output logic [DATA_WIDTH-1:0]   d_rdata,
    output logic                    d_err,
    output logic                    mem_valid,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wmask,
    input  logic                    mem_ready,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic                    busy,
    output logic                    owner
);

    localparam int MW = DATA_WIDTH / 8;
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                  state_reg, state_next;
    logic                    owner_reg, owner_next;
    logic                    last_reg, last_next;
    logic                    we_reg, we_next;
    logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
    logic [DATA_WIDTH-1:0]   wdata_reg, wdata_next;
    logic [MW-1:0]           wmask_reg, wmask_next;
    logic [DATA_WIDTH-1:0]   rdata_reg, rdata_next;
    logic                    err_reg, err_next;
    logic [CW-1:0]           cnt_reg, cnt_next;
    logic                    grant_data;
    logic                    timeout_hit;

    // Data wins when it is the only requester, or on contention if fetch had the last grant.
    assign grant_data  = d_req && (!if_req || !last_reg);
    assign timeout_hit = TIMEOUT_EN && (cnt_reg == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            owner_reg <= 1'b0;
            last_reg  <= 1'b1;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            wmask_reg <= '0;
            rdata_reg <= '0;
            err_reg   <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            owner_reg <= owner_next;
            last_reg  <= last_next;
            we_reg    <= we_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            wmask_reg <= wmask_next;
            rdata_reg <= rdata_next;
            err_reg   <= err_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        owner_next = owner_reg;
        last_next  = last_reg;
        we_next    = we_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        wmask_next = wmask_reg;
        rdata_next = rdata_reg;
        err_next   = err_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (if_req || d_req) begin
                    state_next = BUSY;
                    owner_next = grant_data;
                    last_next  = grant_data;
                    cnt_next   = '0;
                    if (grant_data) begin
                        we_next    = d_we;
                        addr_next  = d_addr;
                        wdata_next = d_wdata;
                        wmask_next = d_wmask;
                    end else begin
                        we_next    = 1'b0;
                        addr_next  = if_addr;
                        wdata_next = '0;
                        wmask_next = '0;
                    end
                end
            end
            BUSY: begin
                cnt_next = cnt_reg + 1'b1;
                if (mem_ready) begin
                    rdata_next = we_reg ? '0 : mem_rdata;
                    err_next   = 1'b0;
                    state_next = DONE;
                end else if (timeout_hit) begin
                    rdata_next = '0;
                    err_next   = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                cnt_next   = '0;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    logic in_busy, in_done;
    assign in_busy = (state_reg == BUSY);
    assign in_done = (state_reg == DONE);

    assign mem_valid = in_busy;
    assign mem_we    = in_busy && we_reg;
    assign mem_addr  = addr_reg;
    assign mem_wdata = wdata_reg;
    assign mem_wmask = wmask_reg;

    // Completion payload is visible only during the owner's ack cycle.
    assign if_ack   = in_done && !owner_reg;
    assign d_ack    = in_done && owner_reg;
    assign if_rdata = if_ack ? rdata_reg : '0;
    assign d_rdata  = d_ack ? rdata_reg : '0;
    assign if_err   = if_ack && err_reg;
    assign d_err    = d_ack && err_reg;

    assign busy  = (state_reg != IDLE);
    assign owner = owner_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: cycle table for arbitration/data paths,
// hand sequences for timeout and reset-during-access.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, d_req, d_we, mem_ready;
    logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic [3:0]  d_wmask;

    logic        if_ack, if_err, d_ack, d_err, mem_valid, mem_we, busy, owner;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_wmask;

    logic        t_if_ack, t_if_err, t_d_ack, t_d_err, t_mem_valid, t_mem_we, t_busy, t_owner;
    logic [31:0] t_if_rdata, t_d_rdata, t_mem_addr, t_mem_wdata;
    logic [3:0]  t_mem_wmask;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wmask(d_wmask),
        .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .busy(busy), .owner(owner)
    );

    mem_port_arbiter #(.TIMEOUT_CYCLES(4)) dut_to (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_ack(t_if_ack), .if_rdata(t_if_rdata), .if_err(t_if_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wmask(d_wmask),
        .d_ack(t_d_ack), .d_rdata(t_d_rdata), .d_err(t_d_err),
        .mem_valid(t_mem_valid), .mem_we(t_mem_we), .mem_addr(t_mem_addr), .mem_wdata(t_mem_wdata),
        .mem_wmask(t_mem_wmask), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .busy(t_busy), .owner(t_owner)
    );

    typedef struct {
        logic        ifr, dr, dwe, rdy;
        logic [31:0] rdata;
        logic        e_valid, e_busy, e_owner, e_we, e_ifack, e_dack;
        logic [31:0] e_rd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic ifr, dr, dwe, rdy, input logic [31:0] rdata,
                                input logic v, b, o, we, ia, da, input logic [31:0] rd);
        vec_t r;
        r.ifr = ifr; r.dr = dr; r.dwe = dwe; r.rdy = rdy; r.rdata = rdata;
        r.e_valid = v; r.e_busy = b; r.e_owner = o; r.e_we = we;
        r.e_ifack = ia; r.e_dack = da; r.e_rd = rd;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        int vcnt;
        bit got;
        if_addr = 32'h10; d_addr = 32'h20; d_wdata = 32'h12345678; d_wmask = 4'hF;
        rst_n = 1'b0;
        if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
        #1;
        check("reset_outputs",
              {if_ack, if_err, d_ack, d_err, mem_valid, mem_we, busy, owner, mem_addr, if_rdata},
              64'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // single fetch, store with 3 waits, contention alternation, continuous fetch
        vecs.push_back(mk(1,0,0,0,0,          0,0,0,0,0,0,0));
        vecs.push_back(mk(1,0,0,1,32'hDEADBEEF,1,1,0,0,0,0,0));
        vecs.push_back(mk(1,0,0,0,0,          0,1,0,0,1,0,32'hDEADBEEF));
        vecs.push_back(mk(0,0,0,0,0,          0,0,0,0,0,0,0));
        vecs.push_back(mk(0,1,1,0,0,          0,0,0,0,0,0,0));
        vecs.push_back(mk(0,1,1,0,0,          1,1,1,1,0,0,0));
        vecs.push_back(mk(0,1,1,0,0,          1,1,1,1,0,0,0));
        vecs.push_back(mk(0,1,1,0,0,          1,1,1,1,0,0,0));
        vecs.push_back(mk(0,1,1,1,32'hAAAA5555,1,1,1,1,0,0,0));
        vecs.push_back(mk(0,1,1,0,0,          0,1,1,0,0,1,0));
        vecs.push_back(mk(0,0,0,0,0,          0,0,1,0,0,0,0));
        vecs.push_back(mk(1,1,0,0,0,          0,0,1,0,0,0,0));
        vecs.push_back(mk(1,1,0,1,32'h11111111,1,1,0,0,0,0,0));
        vecs.push_back(mk(1,1,0,0,0,          0,1,0,0,1,0,32'h11111111));
        vecs.push_back(mk(1,1,0,0,0,          0,0,0,0,0,0,0));
        vecs.push_back(mk(1,1,0,1,32'h22222222,1,1,1,0,0,0,0));
        vecs.push_back(mk(1,1,0,0,0,          0,1,1,0,0,1,32'h22222222));
        vecs.push_back(mk(1,1,0,0,0,          0,0,1,0,0,0,0));
        vecs.push_back(mk(1,1,0,1,32'h33333333,1,1,0,0,0,0,0));
        vecs.push_back(mk(1,1,0,0,0,          0,1,0,0,1,0,32'h33333333));
        vecs.push_back(mk(1,1,0,0,0,          0,0,0,0,0,0,0));
        vecs.push_back(mk(1,1,0,1,32'h44444444,1,1,1,0,0,0,0));
        vecs.push_back(mk(1,1,0,0,0,          0,1,1,0,0,1,32'h44444444));
        vecs.push_back(mk(0,0,0,0,0,          0,0,1,0,0,0,0));
        vecs.push_back(mk(1,0,0,0,0,          0,0,1,0,0,0,0));
        vecs.push_back(mk(1,0,0,1,32'h1,      1,1,0,0,0,0,0));
        vecs.push_back(mk(1,0,0,0,0,          0,1,0,0,1,0,32'h1));
        vecs.push_back(mk(1,0,0,0,0,          0,0,0,0,0,0,0));
        vecs.push_back(mk(1,0,0,1,32'h2,      1,1,0,0,0,0,0));
        vecs.push_back(mk(1,0,0,0,0,          0,1,0,0,1,0,32'h2));
        vecs.push_back(mk(1,0,0,0,0,          0,0,0,0,0,0,0));
        vecs.push_back(mk(1,0,0,1,32'h3,      1,1,0,0,0,0,0));
        vecs.push_back(mk(1,0,0,0,0,          0,1,0,0,1,0,32'h3));
        vecs.push_back(mk(0,0,0,0,0,          0,0,0,0,0,0,0));

        for (int i = 0; i < vecs.size(); i++) begin
            if_req = vecs[i].ifr; d_req = vecs[i].dr; d_we = vecs[i].dwe;
            mem_ready = vecs[i].rdy; mem_rdata = vecs[i].rdata;
            @(negedge clk);
            check($sformatf("row%0d_ctrl", i),
                  {mem_valid, busy, owner, mem_we, if_ack, d_ack, if_err, d_err},
                  {vecs[i].e_valid, vecs[i].e_busy, vecs[i].e_owner, vecs[i].e_we,
                   vecs[i].e_ifack, vecs[i].e_dack, 2'b00});
            check($sformatf("row%0d_rdata", i), {if_rdata, d_rdata},
                  {vecs[i].e_ifack ? vecs[i].e_rd : 32'h0, vecs[i].e_dack ? vecs[i].e_rd : 32'h0});
            if (vecs[i].e_valid)
                check($sformatf("row%0d_mem", i), {mem_addr, mem_wmask},
                      {vecs[i].e_owner ? 32'h20 : 32'h10, vecs[i].e_owner ? 4'hF : 4'h0});
            if (vecs[i].e_valid)
                check($sformatf("row%0d_wdata", i), {32'h0, mem_wdata},
                      {32'h0, vecs[i].e_owner ? 32'h12345678 : 32'h0});
            @(posedge clk);
            #1;
        end

        // watchdog on the TIMEOUT_CYCLES=4 instance
        do_reset();
        d_req = 1'b1; d_we = 1'b0; mem_ready = 1'b0; mem_rdata = 32'h5A5A5A5A;
        vcnt = 0; got = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (t_mem_valid) vcnt++;
            if (t_d_ack) begin
                got = 1;
                check("timeout_err_rdata", {t_d_err, t_d_rdata, t_if_ack}, {1'b1, 32'h0, 1'b0});
                break;
            end
        end
        check("timeout_ack_seen", {63'h0, got}, 64'h1);
        check("timeout_valid_cycles", vcnt, 4);
        @(posedge clk);
        #1 d_req = 1'b0;
        @(negedge clk);
        check("timeout_back_idle", {t_busy, t_mem_valid, t_d_ack}, 3'b000);

        // reset during BUSY
        do_reset();
        if_req = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_reset_busy", {mem_valid, busy}, 2'b11);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_drop", {mem_valid, busy}, 2'b00);
        got = 0;
        repeat (3) begin
            @(negedge clk);
            if (if_ack || d_ack) got = 1;
        end
        check("no_ack_in_reset", {63'h0, got}, 64'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        got = 0;
        for (int k = 0; k < 10; k++) begin
            mem_ready = mem_valid;
            mem_rdata = 32'hCAFEF00D;
            @(negedge clk);
            if (if_ack) begin
                got = 1;
                check("post_reset_fetch", {if_rdata, if_err, d_ack}, {32'hCAFEF00D, 2'b00});
                break;
            end
            @(posedge clk);
            #1;
        end
        check("post_reset_ack_seen", {63'h0, got}, 64'h1);
        if_req = 1'b0; mem_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
